// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and constants for the
// programmable clock divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } div_state_e;

  localparam int MIN_DIV     = 2;
  localparam int DIV_W_DEF   = 8;
  localparam int DEF_DIV_DEF = 10;

endpackage

// File: rtl/div_phase_cnt.sv
// div_phase_cnt: phase counter of the divided clock;
// produces registered clk_out/tick and the boundary flag.
module div_phase_cnt
  import div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] div_nxt_i,
  input  logic             act_i,
  input  logic             run_i,
  output logic             bnd_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] ONE =
    {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] hi_len;
  logic             clk_out_q;
  logic             clk_out_d;
  logic             tick_q;
  logic             tick_d;

  assign bnd_o = act_i &&
    (cnt_q == (div_i - ONE));

  // high phase is ceil(N/2) of the ratio used next
  assign hi_len = (div_nxt_i >> 1) +
    (div_nxt_i & ONE);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (!run_i || !act_i || bnd_o) begin
      cnt_d = '0;
    end
    clk_out_d = run_i && (cnt_d < hi_len);
    tick_d    = run_i && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/div_cfg_ctrl.sv
// div_cfg_ctrl: clock divider with a valid/ready ratio port;
// ratio changes and stops only land on period boundaries.
module div_cfg_ctrl
  import div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] MIN_V =
    DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(DEF_DIV);

  div_state_e       state_q;
  div_state_e       state_d;
  logic [DIV_W-1:0] cur_div_q;
  logic [DIV_W-1:0] cur_div_d;
  logic [DIV_W-1:0] pend_q;
  logic [DIV_W-1:0] pend_d;
  logic             err_q;
  logic             err_d;

  logic xfer;
  logic bad;
  logic ok;
  logic bnd;
  logic act;
  logic run;

  assign cfg_ready = (state_q != ST_PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign bad       = xfer && (cfg_div < MIN_V);
  assign ok        = xfer && !bad;

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    err_d     = bad;
    unique case (state_q)
      ST_IDLE: begin
        if (ok) begin
          cur_div_d = cfg_div;
        end
        if (en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // a ratio accepted while stopping is not lost
        if (bnd && !en) begin
          state_d = ST_IDLE;
          if (ok) begin
            cur_div_d = cfg_div;
          end
        end else if (ok) begin
          pend_d  = cfg_div;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (bnd) begin
          cur_div_d = pend_q;
          state_d   = en ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign act = (state_q != ST_IDLE);
  assign run = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_div_q <= RST_DIV;
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  div_phase_cnt #(
    .DIV_W(DIV_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_i    (cur_div_q),
    .div_nxt_i(cur_div_d),
    .act_i    (act),
    .run_i    (run),
    .bnd_o    (bnd),
    .clk_out_o(clk_out),
    .tick_o   (tick)
  );

  assign cfg_err = err_q;
  assign busy    = act;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// tb_div_cfg_ctrl: directed vector table, reset corner
// sequence and randomized run against a period-level model.
module tb_div_cfg_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] cur_div;

  int checks;
  int errors;

  div_cfg_ctrl #(
    .DIV_W  (8),
    .DEF_DIV(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy),
    .cur_div  (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit v;
    int d;
    int n;
    bit c;
    bit t;
    bit b;
    bit r;
    bit e;
    int cur;
  } vec_t;

  vec_t tbl[$];

  // model: running flag, position in period, ratio,
  // queue of accepted-but-not-yet-applied ratios
  bit m_run;
  int m_pos;
  int m_cur;
  bit m_err;
  int m_pq[$];

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_cur = 10;
    m_err = 1'b0;
    m_pq.delete();
  endtask

  task automatic model_step(bit e, bit v, int d);
    bit rdy;
    bit x;
    bit ok;
    rdy   = (m_pq.size() == 0);
    x     = v && rdy;
    ok    = x && (d >= 2);
    m_err = x && (d < 2);
    if (!m_run) begin
      if (ok) m_cur = d;
      if (e) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == m_cur - 1) begin
      if (m_pq.size() > 0) m_cur = m_pq.pop_front();
      m_pos = 0;
      if (!e) begin
        m_run = 1'b0;
        if (ok) m_cur = d;
      end else if (ok) begin
        m_pq.push_back(d);
      end
    end else begin
      m_pos++;
      if (ok) m_pq.push_back(d);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, bit c, bit t,
                         bit b, bit r, bit e, int cur);
    chk({tag, " clk_out"}, int'(clk_out), int'(c));
    chk({tag, " tick"}, int'(tick), int'(t));
    chk({tag, " busy"}, int'(busy), int'(b));
    chk({tag, " cfg_ready"}, int'(cfg_ready), int'(r));
    chk({tag, " cfg_err"}, int'(cfg_err), int'(e));
    chk({tag, " cur_div"}, int'(cur_div), cur);
  endtask

  task automatic chk_model(string tag);
    chk_all(tag,
            m_run && (m_pos < (m_cur + 1) / 2),
            m_run && (m_pos == 0),
            m_run,
            m_pq.size() == 0,
            m_err,
            m_cur);
  endtask

  task automatic step(bit e, bit v, int d);
    en        = e;
    cfg_valid = v;
    cfg_div   = d[7:0];
    model_step(e, v, d);
    @(posedge clk);
    #1;
  endtask

  bit rnd_e;
  bit rnd_v;
  int rnd_d;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 1, 0, 10);
    rst_n = 1'b1;

    // {en, valid, div, reps, clk, tick, busy, rdy, err, cur}
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 1, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 1, 1, 0, 10});
    tbl.push_back('{1, 1, 1, 1, 1, 0, 1, 1, 1, 10});
    tbl.push_back('{1, 0, 0, 2, 1, 0, 1, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 5, 0, 0, 1, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 1, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 2, 1, 0, 1, 1, 0, 10});
    tbl.push_back('{0, 0, 0, 2, 1, 0, 1, 1, 0, 10});
    tbl.push_back('{0, 0, 0, 2, 0, 0, 1, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 1, 0, 0, 1, 1, 0, 10});
    tbl.push_back('{0, 0, 0, 2, 0, 0, 1, 1, 0, 10});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 10});
    tbl.push_back('{0, 1, 3, 1, 0, 0, 0, 1, 0, 3});
    tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 1, 1, 3});
    tbl.push_back('{0, 1, 10, 1, 0, 0, 0, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 1, 1, 0, 10});
    tbl.push_back('{1, 0, 0, 3, 1, 0, 1, 1, 0, 10});
    tbl.push_back('{1, 1, 7, 1, 1, 0, 1, 0, 0, 10});
    tbl.push_back('{1, 1, 0, 1, 0, 0, 1, 0, 0, 10});
    tbl.push_back('{1, 0, 0, 4, 0, 0, 1, 0, 0, 10});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 1, 1, 0, 7});
    tbl.push_back('{1, 0, 0, 3, 1, 0, 1, 1, 0, 7});
    tbl.push_back('{1, 0, 0, 3, 0, 0, 1, 1, 0, 7});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 1, 1, 0, 7});
    tbl.push_back('{1, 1, 4, 1, 1, 0, 1, 0, 0, 7});
    tbl.push_back('{0, 0, 0, 2, 1, 0, 1, 0, 0, 7});
    tbl.push_back('{0, 0, 0, 3, 0, 0, 1, 0, 0, 7});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 4});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 1, 1, 0, 4});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 1, 1, 0, 4});
    tbl.push_back('{1, 0, 0, 2, 0, 0, 1, 1, 0, 4});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 1, 1, 0, 4});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].en, tbl[i].v, tbl[i].d);
        chk_all($sformatf("tbl%0d", i),
                tbl[i].c, tbl[i].t, tbl[i].b,
                tbl[i].r, tbl[i].e, tbl[i].cur);
      end
    end

    // reset asserted while a ratio is pending
    step(1, 1, 9);
    chk_all("pend", 1, 0, 1, 0, 0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 1, 0, 10);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(0, 0, 0);
    chk_all("post_rst_idle", 0, 0, 0, 1, 0, 10);
    step(1, 0, 0);
    chk_all("post_rst_run", 1, 1, 1, 1, 0, 10);

    for (int i = 0; i < 3000; i++) begin
      rnd_e = ($urandom_range(0, 15) != 0);
      rnd_v = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0)
        rnd_d = $urandom_range(0, 255);
      else
        rnd_d = $urandom_range(0, 9);
      step(rnd_e, rnd_v, rnd_d);
      chk_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
